// File: rtl/gesture_vend_ctrl.sv
// Gesture-driven vending controller.
// A customer browses four items with a "next" gesture, pays with 5/10 coin
// gestures, then confirms. The controller either vends (returning change) or
// refunds. Idle customers are timed out, and the result is shown for a fixed
// dwell time.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   flag[3:0]  - one-cycle gesture pulses: [0] coin 5, [1] coin 10,
//                [2] select-next, [3] confirm/cancel
//   price_put  - amount paid so far
//   price_need - price of the selected item
//   price_out  - change (vend) or refund amount
//   led_value  - {vend_ok, item one-hot[3:0]}
module gesture_vend_ctrl #(
  parameter int unsigned PRICE0      = 15,
  parameter int unsigned PRICE1      = 20,
  parameter int unsigned PRICE2      = 25,
  parameter int unsigned PRICE3      = 35,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned SHOW_CYC    = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flag,
  output logic [6:0] price_put,
  output logic [6:0] price_need,
  output logic [6:0] price_out,
  output logic [4:0] led_value
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StPay, StVend, StRefund} state_e;

  state_e          state_q, state_d;
  logic [1:0]      item_q, item_d;
  // Shared between the idle timeout (SELECT/PAY) and the dwell (VEND/REFUND).
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      put_q, put_d;
  logic [6:0]      need_q, need_d;
  logic [6:0]      out_q, out_d;
  logic [4:0]      led_q, led_d;

  logic       ev_valid, ev_coin, ev_next, ev_conf;
  logic [7:0] coin_sum;
  logic [6:0] put_coin;

  function automatic logic [6:0] price_of(input logic [1:0] item);
    logic [6:0] p;
    unique case (item)
      2'd0:    p = 7'(PRICE0);
      2'd1:    p = 7'(PRICE1);
      2'd2:    p = 7'(PRICE2);
      default: p = 7'(PRICE3);
    endcase
    return p;
  endfunction

  // Multi-bit or empty flag words are not events.
  assign ev_valid = $onehot(flag);
  assign ev_coin  = ev_valid & (flag[0] | flag[1]);
  assign ev_next  = ev_valid & flag[2];
  assign ev_conf  = ev_valid & flag[3];

  // 8-bit sum so the clamp sees the true total.
  assign coin_sum = {1'b0, put_q} + (flag[1] ? 8'd10 : 8'd5);
  assign put_coin = (coin_sum > 8'd99) ? 7'd99 : coin_sum[6:0];

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    cnt_d   = cnt_q;
    put_d   = put_q;
    need_d  = need_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (ev_next) begin
          state_d = StSelect;
          item_d  = 2'd0;
          need_d  = price_of(2'd0);
          put_d   = 7'd0;
          out_d   = 7'd0;
          cnt_d   = '0;
        end
      end

      StSelect, StPay: begin
        if (ev_valid) begin
          cnt_d = '0;
          if (ev_next) begin
            // Item is locked once money is in.
            if (state_q == StSelect) begin
              item_d = item_q + 2'd1;
              need_d = price_of(item_q + 2'd1);
            end
          end else if (ev_coin) begin
            state_d = StPay;
            put_d   = put_coin;
          end else if (ev_conf) begin
            if (state_q == StSelect) begin
              state_d = StIdle;
              item_d  = 2'd0;
              need_d  = 7'd0;
              put_d   = 7'd0;
              out_d   = 7'd0;
            end else if (put_q >= need_q) begin
              state_d = StVend;
              out_d   = put_q - need_q;
            end else begin
              state_d = StRefund;
              out_d   = put_q;
            end
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d = StRefund;
          out_d   = put_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StVend, StRefund: begin
        if (cnt_q == CntW'(SHOW_CYC - 1)) begin
          state_d = StIdle;
          item_d  = 2'd0;
          need_d  = 7'd0;
          put_d   = 7'd0;
          out_d   = 7'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        item_d  = 2'd0;
        need_d  = 7'd0;
        put_d   = 7'd0;
        out_d   = 7'd0;
        cnt_d   = '0;
      end
    endcase

    // LEDs are registered from the next state so they change with the other outputs.
    led_d = 5'd0;
    unique case (state_d)
      StSelect, StPay: led_d = {1'b0, 4'b0001 << item_d};
      StVend:          led_d = {1'b1, 4'b0001 << item_d};
      default:         led_d = 5'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      item_q  <= 2'd0;
      cnt_q   <= '0;
      put_q   <= 7'd0;
      need_q  <= 7'd0;
      out_q   <= 7'd0;
      led_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      cnt_q   <= cnt_d;
      put_q   <= put_d;
      need_q  <= need_d;
      out_q   <= out_d;
      led_q   <= led_d;
    end
  end

  assign price_put  = put_q;
  assign price_need = need_q;
  assign price_out  = out_q;
  assign led_value  = led_q;

endmodule

// File: tb/tb_gesture_vend_ctrl.sv
// Testbench for gesture_vend_ctrl: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run checked against a transaction-level
// model of the vending rules.
module tb_gesture_vend_ctrl;

  localparam int TMO  = 100;
  localparam int SHOW = 20;

  logic       clk;
  logic       rst;
  logic [3:0] flag;
  logic [6:0] price_put, price_need, price_out;
  logic [4:0] led_value;

  int tests;
  int fails;

  gesture_vend_ctrl #(
    .TIMEOUT_CYC(TMO),
    .SHOW_CYC   (SHOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flag      (flag),
    .price_put (price_put),
    .price_need(price_need),
    .price_out (price_out),
    .led_value (led_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int put, input int need, input int out,
                           input int led);
    check({tag, ".put"},  int'(price_put),  put);
    check({tag, ".need"}, int'(price_need), need);
    check({tag, ".out"},  int'(price_out),  out);
    check({tag, ".led"},  int'(led_value),  led);
  endtask

  // Drive one cycle of flag, starting and ending 1 time unit after a rising edge.
  task automatic pulse(input logic [3:0] f);
    flag = f;
    @(posedge clk);
    #1;
    flag = 4'b0000;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) pulse(4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flag = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  localparam int PhIdle = 0, PhSel = 1, PhPay = 2, PhVend = 3, PhRef = 4;
  int price[4] = '{15, 20, 25, 35};
  int m_phase, m_item, m_put, m_need, m_out, m_quiet, m_dwell;

  task automatic model_reset();
    m_phase = PhIdle; m_item = 0; m_put = 0; m_need = 0; m_out = 0;
    m_quiet = 0; m_dwell = 0;
  endtask

  task automatic model_clear();
    m_phase = PhIdle; m_item = 0; m_put = 0; m_need = 0; m_out = 0;
  endtask

  task automatic model_step(input logic [3:0] f);
    bit ev;
    ev = ($countones(f) == 1);
    if (m_phase == PhIdle) begin
      if (ev && f[2]) begin
        m_phase = PhSel; m_item = 0; m_need = price[0]; m_quiet = 0;
      end
    end else if (m_phase == PhSel || m_phase == PhPay) begin
      if (ev) begin
        m_quiet = 0;
        if (f[2]) begin
          if (m_phase == PhSel) begin
            m_item = (m_item + 1) % 4;
            m_need = price[m_item];
          end
        end else if (f[0] || f[1]) begin
          m_put = m_put + (f[1] ? 10 : 5);
          if (m_put > 99) m_put = 99;
          m_phase = PhPay;
        end else if (m_phase == PhSel) begin
          model_clear();
        end else begin
          m_phase = (m_put >= m_need) ? PhVend : PhRef;
          m_out   = (m_put >= m_need) ? m_put - m_need : m_put;
          m_dwell = 0;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          m_phase = PhRef; m_out = m_put; m_dwell = 0;
        end
      end
    end else begin
      m_dwell++;
      if (m_dwell == SHOW) model_clear();
    end
  endtask

  function automatic int model_led();
    if (m_phase == PhSel || m_phase == PhPay) return 1 << m_item;
    if (m_phase == PhVend) return 16 | (1 << m_item);
    return 0;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] f;
    int         put;
    int         need;
    int         out;
    int         led;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int quiet_left;
    logic [3:0] f;
    int r;

    tests = 0;
    fails = 0;
    flag  = 4'b0000;
    rst   = 1'b1;

    // Outputs are zero while in reset.
    @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    vecs[0]  = '{4'b0011, 0,  0,  0, 5'b00000};  // multi-bit in IDLE ignored
    vecs[1]  = '{4'b0100, 0, 15,  0, 5'b00001};  // first event after reset
    vecs[2]  = '{4'b0100, 0, 20,  0, 5'b00010};
    vecs[3]  = '{4'b0100, 0, 25,  0, 5'b00100};
    vecs[4]  = '{4'b0100, 0, 35,  0, 5'b01000};
    vecs[5]  = '{4'b0100, 0, 15,  0, 5'b00001};  // wrap 3 -> 0
    vecs[6]  = '{4'b0010, 10, 15, 0, 5'b00001};  // coin 10 -> PAY
    vecs[7]  = '{4'b0011, 10, 15, 0, 5'b00001};  // multi-bit in PAY ignored
    vecs[8]  = '{4'b0100, 10, 15, 0, 5'b00001};  // item locked
    vecs[9]  = '{4'b0010, 20, 15, 0, 5'b00001};
    vecs[10] = '{4'b1000, 20, 15, 5, 5'b10001};  // VEND, change 5
    vecs[11] = '{4'b0100, 20, 15, 5, 5'b10001};  // ignored in VEND

    for (int i = 0; i < 12; i++) begin
      pulse(vecs[i].f);
      check_all($sformatf("vec%0d", i), vecs[i].put, vecs[i].need, vecs[i].out, vecs[i].led);
    end

    // VEND dwell: entered at vec10's edge, back to IDLE SHOW edges later.
    quiet(SHOW - 2);
    check("vend_dwell_hold.led", int'(led_value), 5'b10001);
    pulse(4'b0000);
    check_all("vend_to_idle", 0, 0, 0, 0);

    // Underpaid confirm -> REFUND.
    pulse(4'b0100); pulse(4'b0100); pulse(4'b0100);
    pulse(4'b0010); pulse(4'b0010);
    pulse(4'b1000);
    check_all("refund", 20, 25, 20, 0);
    quiet(SHOW - 1);
    check("refund_hold.out", int'(price_out), 20);
    pulse(4'b0000);
    check_all("refund_to_idle", 0, 0, 0, 0);

    // Saturation at 99.
    pulse(4'b0100);
    for (int i = 0; i < 12; i++) begin
      pulse(4'b0010);
      if (int'(price_put) > 99) check("sat_over99", int'(price_put), 99);
    end
    check("sat.put", int'(price_put), 99);
    pulse(4'b0001);
    check("sat_coin5.put", int'(price_put), 99);
    do_reset();

    // Idle timeout in PAY.
    pulse(4'b0100);
    pulse(4'b0001);
    quiet(TMO - 1);
    check_all("tmo_before", 5, 15, 0, 5'b00001);
    pulse(4'b0000);
    check_all("tmo_refund", 5, 15, 5, 0);
    do_reset();

    // Asynchronous reset mid-VEND, then normal operation.
    pulse(4'b0100); pulse(4'b0010); pulse(4'b0010); pulse(4'b1000);
    check("pre_rst.led", int'(led_value), 5'b10001);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse(4'b0100);
    check_all("post_rst_select", 0, 15, 0, 5'b00001);
    for (int i = 0; i < 5; i++) pulse(4'b0100);
    check_all("select_x5", 0, 20, 0, 5'b00010);

    // ---------------- randomized run ----------------
    do_reset();
    model_reset();
    quiet_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (quiet_left == 0 && $urandom_range(0, 59) == 0) quiet_left = $urandom_range(90, 110);
      if (quiet_left > 0) begin
        quiet_left--;
        f = 4'b0000;
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 50)      f = 4'b0000;
        else if (r < 62) f = 4'b0001;
        else if (r < 74) f = 4'b0010;
        else if (r < 84) f = 4'b0100;
        else if (r < 90) f = 4'b1000;
        else             f = 4'($urandom_range(0, 15));
      end
      model_step(f);
      pulse(f);
      check_all($sformatf("rnd%0d", n), m_put, m_need, m_out, model_led());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gesture_vend_ctrl.md
GESTURE_VEND_CTRL -- requirements
Module: gesture_vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE0, default 15, price of item 0.
REQ-002 SHALL have parameter PRICE1, default 20, price of item 1.
REQ-003 SHALL have parameter PRICE2, default 25, price of item 2.
REQ-004 SHALL have parameter PRICE3, default 35, price of item 3; all prices 1..99.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 500_000_000, idle-gesture timeout in SELECT/PAY (10 s at 50 MHz).
REQ-006 SHALL have parameter SHOW_CYC, default 150_000_000, dwell time in VEND/REFUND (3 s).
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port flag, input, 4, one-cycle gesture pulses: [0] coin 5, [1] coin 10, [2] select-next, [3] confirm/cancel.
REQ-010 SHALL have port price_put, output, 7, amount paid so far.
REQ-011 SHALL have port price_need, output, 7, price of the selected item.
REQ-012 SHALL have port price_out, output, 7, change or refund amount.
REQ-013 SHALL have port led_value, output, 5, {vend_ok, item one-hot[3:0]}.

Function
REQ-014 SHALL implement states IDLE, SELECT, PAY, VEND, REFUND; all outputs registered, updated the cycle after the causing flag pulse.
REQ-015 SHALL treat flag with zero or more than one bit set as no event.
REQ-016 IDLE: outputs 0; flag[2] -> SELECT, item=0, price_need=PRICE0; other events ignored.
REQ-017 SELECT: flag[2] advances item 0->1->2->3->0 with price_need updated; flag[0]/[1] -> PAY and adds coin; flag[3] -> IDLE, nothing refunded.
REQ-018 PAY: flag[0]/[1] add 5/10 to price_put, clamped to 99; flag[2] ignored (item locked).
REQ-019 PAY, flag[3] with price_put >= price_need: -> VEND, price_out = price_put - price_need.
REQ-020 PAY, flag[3] with price_put < price_need: -> REFUND, price_out = price_put.
REQ-021 SELECT/PAY: a timeout counter SHALL clear on every valid event and on state entry; reaching TIMEOUT_CYC-1 -> REFUND with price_out = price_put (0 if SELECT).
REQ-022 VEND/REFUND: all flag events ignored; dwell counter runs SHOW_CYC cycles, then -> IDLE with all outputs cleared in the same cycle.
REQ-023 led_value[3:0] SHALL be one-hot of item in SELECT, PAY, VEND, else 0; led_value[4] SHALL be 1 only in VEND.
REQ-024 price_need and price_put SHALL hold their values in VEND and REFUND.
REQ-025 Counters SHALL be wide enough for max(TIMEOUT_CYC, SHOW_CYC); no arithmetic SHALL wrap.

Reset
REQ-026 rst high SHALL force IDLE, item 0, all counters and all outputs to 0 immediately, including mid-VEND/REFUND.
REQ-027 First event after rst release SHALL be processed normally on the first clk edge with rst low.

Verification (TIMEOUT_CYC=100, SHOW_CYC=20)
REQ-028 flag[2] x3, coin 10, coin 10, flag[3] -> price_need=25, price_put=20, REFUND, price_out=20, led_value=0, IDLE after 20 cycles.
REQ-029 flag[2], coin 10, coin 10, flag[3] -> price_need=15, price_put=20, VEND, price_out=5, led_value=5'b10001.
REQ-030 flag[2], twelve coin 10 pulses -> price_put saturates at 99, never 100+.
REQ-031 flag[2], coin 5, no events for 100 cycles -> REFUND, price_out=5.
REQ-032 flag=4'b0011 in IDLE/PAY -> no state or output change; flag[2] x5 in SELECT -> item 1, price_need=20.
REQ-033 rst asserted mid-VEND -> all outputs 0 asynchronously; next flag[2] -> SELECT, item 0.
